mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS CPU; sequences the PC register, the instruction register (IR), the GRF, the ALU and the DM through fetch/decode/execute/memory/writeback.
- Sits beside the datapath: consumes the IR contents and the ALU zero flag, and drives every write enable and mux select.
- One instruction is in flight at a time; `retire` pulses in the final cycle of each instruction for the bench and for trace logic.

Parameters:
- none (opcode/funct encodings fixed below)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr  in  32  IR output; stable from DECODE through the instruction's last cycle
- zero  in  1  ALU equal flag (rs==rt), valid in EXEC
- pc_we  out  1  PC register write enable
- ir_we  out  1  IR write enable
- npc_sel  out  2  0=PC+4, 1=PC+(sext(imm16)<<2), 2={PC[31:28],imm26,2'b00}, 3=GRF[rs]
- reg_we  out  1  GRF write enable
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- wd_sel  out  2  0=ALU result, 1=DM read data, 2=PC (already PC+4)
- alu_src  out  1  0=GRF[rt], 1=extended imm
- alu_op  out  3  0=add, 1=sub, 2=or, 3=lui (imm<<16)
- ext_op  out  1  0=zero-extend, 1=sign-extend
- mem_we  out  1  DM write enable
- state  out  3  current state, for debug
- retire  out  1  one-cycle pulse on the last cycle of an instruction

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5-7 are illegal and go to FETCH on the next edge with all enables 0.
- Reset: at a posedge with reset=1, state<=FETCH. While reset=1, pc_we, ir_we, reg_we, mem_we and retire are forced 0 combinationally; all selects are 0.
- Outputs are combinational from state and the decoded instr. All selects are 0 unless stated.
- Decode set:
  - R-type (op 000000): addu (funct 100001), subu (100011), jr (001000).
  - I/J-type: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
  - Anything else, including sll/nop, is UNKNOWN.
- FETCH: ir_we=1, pc_we=1, npc_sel=0. Next state is DECODE.
- DECODE:
  - j: pc_we=1, npc_sel=2, retire=1; next FETCH.
  - jal: pc_we=1, npc_sel=2, reg_we=1, reg_dst=2, wd_sel=2, retire=1; next FETCH. PC is sampled before the update, so $31 receives the old PC+4.
  - jr: pc_we=1, npc_sel=3, retire=1; next FETCH.
  - UNKNOWN: retire=1, no writes; next FETCH.
  - Every other instruction: no writes; next EXEC.
- EXEC:
  - addu/subu: alu_src=0, alu_op=0/1; next WB.
  - ori: alu_src=1, ext_op=0, alu_op=2; next WB.
  - lui: alu_src=1, alu_op=3; next WB.
  - lw/sw: alu_src=1, ext_op=1, alu_op=0; next MEM.
  - beq: alu_op=1, ext_op=1, pc_we=zero, npc_sel=1, retire=1; next FETCH.
- MEM:
  - sw: mem_we=1, alu_src=1, ext_op=1, alu_op=0, retire=1; next FETCH.
  - lw: address held (same selects as EXEC); next WB.
- WB: reg_we=1, retire=1; next FETCH.
  - addu/subu: reg_dst=1, wd_sel=0, with alu selects held from EXEC.
  - ori/lui: reg_dst=0, wd_sel=0, with alu selects held from EXEC.
  - lw: reg_dst=0, wd_sel=1.
- Cycle counts: j/jal/jr/UNKNOWN 2; beq 3; addu/subu/ori/lui/sw 4; lw 5.
- Reset mid-instruction: state returns to FETCH at that edge. No partial write is issued in the reset cycle; writes completed in earlier cycles stand.
- Register write to $0 is still asserted; the GRF discards it.
- Exactly one retire pulse per instruction, never two in consecutive cycles within one instruction.

Test Plan:
- Reset: hold reset 2 cycles from arbitrary state -> state=0, all enables 0 during reset; first cycle after release ir_we=1, pc_we=1, npc_sel=0.
- ori then lui: instr=0x34010005 -> states 0,1,2,4; in WB reg_we=1, reg_dst=0, alu_op=2, ext_op=0. instr=0x3C021234 -> WB with alu_op=3; retire once per instruction.
- lw/sw: instr=0x8C430004 -> states 0,1,2,3,4, WB wd_sel=1. instr=0xAC430004 -> MEM mem_we=1, retire=1, 4 cycles total, reg_we never 1.
- beq: instr=0x10220003 with zero=1 -> EXEC pc_we=1, npc_sel=1. Same instr with zero=0 -> EXEC pc_we=0; both 3 cycles.
- Jumps and unknown:
  - instr=0x0C000C10 (jal) -> DECODE pc_we=1, npc_sel=2, reg_we=1, reg_dst=2, wd_sel=2.
  - instr=0x03E00008 (jr) -> npc_sel=3.
  - instr=0x00000000 -> 2 cycles, no writes besides FETCH.
- Mid-op reset: assert reset during MEM of sw -> mem_we=0 that cycle, state=0 next.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the datapath enables and mux selects combinationally from state and IR.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        pc_we,
  output logic        ir_we,
  output logic [1:0]  npc_sel,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        ext_op,
  output logic        mem_we,
  output logic [2:0]  state,
  output logic        retire
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_J, I_JAL, I_UNK
  } instr_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  state_t     cur_state;
  state_t     nxt_state;
  instr_t     kind;
  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign state  = cur_state;

  // Register fields and immediates feed the datapath directly, not the controller.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    kind = I_UNK;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: kind = I_ADDU;
          6'b100011: kind = I_SUBU;
          6'b001000: kind = I_JR;
          default:   kind = I_UNK;
        endcase
      end
      6'b001101: kind = I_ORI;
      6'b100011: kind = I_LW;
      6'b101011: kind = I_SW;
      6'b000100: kind = I_BEQ;
      6'b001111: kind = I_LUI;
      6'b000010: kind = I_J;
      6'b000011: kind = I_JAL;
      default:   kind = I_UNK;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    npc_sel   = 2'd0;
    reg_we    = 1'b0;
    reg_dst   = 2'd0;
    wd_sel    = 2'd0;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    ext_op    = 1'b0;
    mem_we    = 1'b0;
    retire    = 1'b0;
    nxt_state = S_FETCH;

    case (cur_state)
      S_FETCH: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        nxt_state = S_DECODE;
      end
      S_DECODE: begin
        case (kind)
          I_J: begin
            pc_we   = 1'b1;
            npc_sel = 2'd2;
            retire  = 1'b1;
          end
          I_JAL: begin
            // PC already holds PC+4 here, so $31 captures the return address.
            pc_we   = 1'b1;
            npc_sel = 2'd2;
            reg_we  = 1'b1;
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
            retire  = 1'b1;
          end
          I_JR: begin
            pc_we   = 1'b1;
            npc_sel = 2'd3;
            retire  = 1'b1;
          end
          I_UNK:   retire    = 1'b1;
          default: nxt_state = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (kind)
          I_ADDU: begin
            alu_op    = ALU_ADD;
            nxt_state = S_WB;
          end
          I_SUBU: begin
            alu_op    = ALU_SUB;
            nxt_state = S_WB;
          end
          I_ORI: begin
            alu_src   = 1'b1;
            alu_op    = ALU_OR;
            nxt_state = S_WB;
          end
          I_LUI: begin
            alu_src   = 1'b1;
            alu_op    = ALU_LUI;
            nxt_state = S_WB;
          end
          I_LW, I_SW: begin
            alu_src   = 1'b1;
            ext_op    = 1'b1;
            nxt_state = S_MEM;
          end
          I_BEQ: begin
            alu_op  = ALU_SUB;
            ext_op  = 1'b1;
            pc_we   = zero;
            npc_sel = 2'd1;
            retire  = 1'b1;
          end
          default: nxt_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        case (kind)
          I_SW: begin
            mem_we  = 1'b1;
            alu_src = 1'b1;
            ext_op  = 1'b1;
            retire  = 1'b1;
          end
          I_LW: begin
            // Keep the address stable while the DM read completes.
            alu_src   = 1'b1;
            ext_op    = 1'b1;
            nxt_state = S_WB;
          end
          default: nxt_state = S_FETCH;
        endcase
      end
      S_WB: begin
        case (kind)
          I_ADDU, I_SUBU: begin
            reg_we  = 1'b1;
            reg_dst = 2'd1;
            alu_op  = (kind == I_SUBU) ? ALU_SUB : ALU_ADD;
            retire  = 1'b1;
          end
          I_ORI: begin
            reg_we  = 1'b1;
            alu_src = 1'b1;
            alu_op  = ALU_OR;
            retire  = 1'b1;
          end
          I_LUI: begin
            reg_we  = 1'b1;
            alu_src = 1'b1;
            alu_op  = ALU_LUI;
            retire  = 1'b1;
          end
          I_LW: begin
            reg_we = 1'b1;
            wd_sel = 2'd1;
            retire = 1'b1;
          end
          default: nxt_state = S_FETCH;
        endcase
      end
      default: nxt_state = S_FETCH;
    endcase

    // Reset suppresses every write, including one that would land mid-instruction.
    if (reset) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      npc_sel = 2'd0;
      reg_we  = 1'b0;
      reg_dst = 2'd0;
      wd_sel  = 2'd0;
      alu_src = 1'b0;
      alu_op  = ALU_ADD;
      ext_op  = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= nxt_state;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle state and packed control vector against hand-computed values.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        pc_we, ir_we, reg_we, alu_src, ext_op, mem_we, retire;
  logic [1:0]  npc_sel, reg_dst, wd_sel;
  logic [2:0]  alu_op, state;

  int errors = 0;
  int checks = 0;

  // {pc_we, ir_we, npc_sel, reg_we, reg_dst, wd_sel, alu_src, alu_op, ext_op, mem_we, retire}
  logic [15:0] ctl;
  assign ctl = {pc_we, ir_we, npc_sel, reg_we, reg_dst, wd_sel, alu_src, alu_op, ext_op, mem_we, retire};

  logic [2:0]  exp_st  [5];
  logic [15:0] exp_ctl [5];

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .instr   (instr),
    .zero    (zero),
    .pc_we   (pc_we),
    .ir_we   (ir_we),
    .npc_sel (npc_sel),
    .reg_we  (reg_we),
    .reg_dst (reg_dst),
    .wd_sel  (wd_sel),
    .alu_src (alu_src),
    .alu_op  (alu_op),
    .ext_op  (ext_op),
    .mem_we  (mem_we),
    .state   (state),
    .retire  (retire)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr = 32'h0;
    zero  = 1'b0;
    #1;
    checks++;
    if (ctl !== 16'h0) begin errors++; $display("FAIL reset_t0: ctl=%h want 0000", ctl); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (state !== 3'd0) begin errors++; $display("FAIL reset_state c%0d: state=%0d want 0", c, state); end
      checks++;
      if (ctl !== 16'h0) begin errors++; $display("FAIL reset_ctl c%0d: ctl=%h want 0000", c, ctl); end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== 16'hC000 || state !== 3'd0)
      begin errors++; $display("FAIL reset_release: state=%0d ctl=%h want 0/c000", state, ctl); end
  endtask

  task automatic test_ori_lui();
    exp_st  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    exp_ctl = '{16'hC000, 16'h0000, 16'h0050, 16'h0851, 16'h0};
    instr = 32'h34010005;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (state !== exp_st[c]) begin errors++; $display("FAIL ori_state c%0d: state=%0d want %0d", c, state, exp_st[c]); end
      checks++;
      if (ctl !== exp_ctl[c]) begin errors++; $display("FAIL ori_ctl c%0d: ctl=%h want %h", c, ctl, exp_ctl[c]); end
      tick();
    end
    exp_ctl = '{16'hC000, 16'h0000, 16'h0058, 16'h0859, 16'h0};
    instr = 32'h3C021234;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (state !== exp_st[c]) begin errors++; $display("FAIL lui_state c%0d: state=%0d want %0d", c, state, exp_st[c]); end
      checks++;
      if (ctl !== exp_ctl[c]) begin errors++; $display("FAIL lui_ctl c%0d: ctl=%h want %h", c, ctl, exp_ctl[c]); end
      tick();
    end
  endtask

  task automatic test_alu_rtype();
    exp_st  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    exp_ctl = '{16'hC000, 16'h0000, 16'h0000, 16'h0A01, 16'h0};
    instr = 32'h00221821;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (state !== exp_st[c]) begin errors++; $display("FAIL addu_state c%0d: state=%0d want %0d", c, state, exp_st[c]); end
      checks++;
      if (ctl !== exp_ctl[c]) begin errors++; $display("FAIL addu_ctl c%0d: ctl=%h want %h", c, ctl, exp_ctl[c]); end
      tick();
    end
    exp_ctl = '{16'hC000, 16'h0000, 16'h0008, 16'h0A09, 16'h0};
    instr = 32'h00221823;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (state !== exp_st[c]) begin errors++; $display("FAIL subu_state c%0d: state=%0d want %0d", c, state, exp_st[c]); end
      checks++;
      if (ctl !== exp_ctl[c]) begin errors++; $display("FAIL subu_ctl c%0d: ctl=%h want %h", c, ctl, exp_ctl[c]); end
      tick();
    end
  endtask

  task automatic test_load_store();
    exp_st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    exp_ctl = '{16'hC000, 16'h0000, 16'h0044, 16'h0044, 16'h0881};
    instr = 32'h8C430004;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (state !== exp_st[c]) begin errors++; $display("FAIL lw_state c%0d: state=%0d want %0d", c, state, exp_st[c]); end
      checks++;
      if (ctl !== exp_ctl[c]) begin errors++; $display("FAIL lw_ctl c%0d: ctl=%h want %h", c, ctl, exp_ctl[c]); end
      tick();
    end
    exp_st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    exp_ctl = '{16'hC000, 16'h0000, 16'h0044, 16'h0047, 16'h0};
    instr = 32'hAC430004;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (state !== exp_st[c]) begin errors++; $display("FAIL sw_state c%0d: state=%0d want %0d", c, state, exp_st[c]); end
      checks++;
      if (ctl !== exp_ctl[c]) begin errors++; $display("FAIL sw_ctl c%0d: ctl=%h want %h", c, ctl, exp_ctl[c]); end
      tick();
    end
  endtask

  task automatic test_beq();
    exp_st  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0};
    exp_ctl = '{16'hC000, 16'h0000, 16'h900D, 16'h0, 16'h0};
    instr = 32'h10220003;
    zero  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (state !== exp_st[c]) begin errors++; $display("FAIL beq_t_state c%0d: state=%0d want %0d", c, state, exp_st[c]); end
      checks++;
      if (ctl !== exp_ctl[c]) begin errors++; $display("FAIL beq_t_ctl c%0d: ctl=%h want %h", c, ctl, exp_ctl[c]); end
      tick();
    end
    exp_ctl = '{16'hC000, 16'h0000, 16'h100D, 16'h0, 16'h0};
    zero  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (state !== exp_st[c]) begin errors++; $display("FAIL beq_nt_state c%0d: state=%0d want %0d", c, state, exp_st[c]); end
      checks++;
      if (ctl !== exp_ctl[c]) begin errors++; $display("FAIL beq_nt_ctl c%0d: ctl=%h want %h", c, ctl, exp_ctl[c]); end
      tick();
    end
  endtask

  task automatic test_jumps();
    logic [31:0] jins [4];
    logic [15:0] jctl [4];
    jins = '{32'h0C000C10, 32'h03E00008, 32'h08000010, 32'h00000000};
    jctl = '{16'hAD01, 16'hB001, 16'hA001, 16'h0001};
    for (int k = 0; k < 4; k++) begin
      instr = jins[k];
      #1;
      checks++;
      if (state !== 3'd0 || ctl !== 16'hC000)
        begin errors++; $display("FAIL jump%0d_fetch: state=%0d ctl=%h want 0/c000", k, state, ctl); end
      tick();
      #1;
      checks++;
      if (state !== 3'd1) begin errors++; $display("FAIL jump%0d_state: state=%0d want 1", k, state); end
      checks++;
      if (ctl !== jctl[k]) begin errors++; $display("FAIL jump%0d_ctl: ctl=%h want %h", k, ctl, jctl[k]); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    // Arbitrary-state reset: interrupt ori in EXEC, hold reset two cycles.
    instr = 32'h34010005;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd2 || ctl !== 16'h0)
      begin errors++; $display("FAIL rst_exec: state=%0d ctl=%h want 2/0000", state, ctl); end
    tick();
    tick();
    checks++;
    if (state !== 3'd0 || ctl !== 16'h0)
      begin errors++; $display("FAIL rst_exec_after: state=%0d ctl=%h want 0/0000", state, ctl); end
    reset = 1'b0;
    #1;
    // Reset during MEM of sw must suppress the store.
    instr = 32'hAC430004;
    tick();
    tick();
    tick();
    checks++;
    if (state !== 3'd3 || ctl !== 16'h0047)
      begin errors++; $display("FAIL sw_mem_pre: state=%0d ctl=%h want 3/0047", state, ctl); end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || ctl !== 16'h0)
      begin errors++; $display("FAIL sw_mem_rst: mem_we=%b ctl=%h want 0/0000", mem_we, ctl); end
    tick();
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL sw_rst_state: state=%0d want 0", state); end
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== 16'hC000) begin errors++; $display("FAIL sw_rst_release: ctl=%h want c000", ctl); end
  endtask

  initial begin
    test_reset();
    test_ori_lui();
    test_alu_rtype();
    test_load_store();
    test_beq();
    test_jumps();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
